mdu_iterative: RTL and testbench

// Iterative RV32M multiply/divide unit for the execute stage, parallel to the ALU.

---
 rtl/mdu_if.sv | 26 ++
 rtl/mdu_iterative.sv | 140 ++++++++++++++
 tb/tb_mdu_iterative.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Purpose : operand/result bundle between the execute stage and the iterative MDU.
// Latency : n/a (wiring only); the MDU defines timing.
// Backpressure: none; start is only taken while the unit is idle, busy tells the pipeline to stall.
// Ports   : start, abort, funct3, MDU_in_X, MDU_in_Y (to MDU); MDU_out_S, busy, done (from MDU).
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] MDU_in_X;
  logic [WIDTH-1:0] MDU_in_Y;
  logic [WIDTH-1:0] MDU_out_S;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, funct3, MDU_in_X, MDU_in_Y,
    input  MDU_out_S, busy, done
  );

  modport slave (
    input  start, abort, funct3, MDU_in_X, MDU_in_Y,
    output MDU_out_S, busy, done
  );
endinterface

// File: rtl/mdu_iterative.sv
// Purpose : iterative RV32M multiply/divide (shift-add multiply, restoring divide).
// Latency : done WIDTH+2 edges after the accepting edge; divide-by-zero/overflow 1 edge.
// Backpressure: start ignored unless idle; busy stalls the pipeline; abort cancels CALC/FIX.
// Ports   : clk, rst_n (sync, active-low); mdu (slave): start, abort, funct3, MDU_in_X,
//           MDU_in_Y in; MDU_out_S (held until next result), busy, done (1-cycle pulse) out.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave mdu
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]         op;
  logic               neg_q;     // product or quotient must be negated
  logic               neg_r;     // remainder takes the dividend sign
  logic [WIDTH-1:0]   opb;       // |Y|: multiplicand addend or divisor
  logic [2*WIDTH-1:0] acc;       // multiply: {product hi, multiplier/product lo}; divide: {rem, quot}
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   out_q;
  logic               done_q;

  // Input decode, used only in IDLE.
  logic             in_div, x_signed, y_signed, sx, sy, div_zero, div_ovf, special, accept;
  logic [WIDTH-1:0] x_mag, y_mag, special_res;

  always_comb begin
    in_div   = mdu.funct3[2];
    x_signed = (mdu.funct3 == 3'b001) || (mdu.funct3 == 3'b010) || (in_div && !mdu.funct3[0]);
    y_signed = (mdu.funct3 == 3'b001) || (in_div && !mdu.funct3[0]);
    sx       = x_signed && mdu.MDU_in_X[WIDTH-1];
    sy       = y_signed && mdu.MDU_in_Y[WIDTH-1];
    x_mag    = sx ? -mdu.MDU_in_X : mdu.MDU_in_X;
    y_mag    = sy ? -mdu.MDU_in_Y : mdu.MDU_in_Y;
    div_zero = in_div && (mdu.MDU_in_Y == '0);
    div_ovf  = in_div && !mdu.funct3[0] && (mdu.MDU_in_X == MIN_NEG) && (mdu.MDU_in_Y == '1);
    special  = div_zero || div_ovf;
    // funct3[1] separates REM(U) from DIV(U)
    if (div_zero) special_res = mdu.funct3[1] ? mdu.MDU_in_X : '1;
    else          special_res = mdu.funct3[1] ? '0 : MIN_NEG;
    accept   = (state == S_IDLE) && mdu.start && !mdu.abort;
  end

  // One iteration of each algorithm.
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    // Trial subtract of the divisor from {rem, next dividend bit}; keep it if no borrow.
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction and result select.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_raw = acc[WIDTH-1:0];
    rem_raw  = acc[2*WIDTH-1:WIDTH];
    quot_fix = neg_q ? -quot_raw : quot_raw;
    rem_fix  = neg_r ? -rem_raw : rem_raw;
    case (op)
      3'b000:                 fix_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (mdu.abort)        state_nxt = S_IDLE;
        else if (cnt == '0)   state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = mdu.abort ? S_IDLE : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      res    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          op    <= mdu.funct3;
          neg_q <= sx ^ sy;
          neg_r <= sx;
          opb   <= y_mag;
          acc   <= {{WIDTH{1'b0}}, x_mag};
          cnt   <= CW'(WIDTH - 1);
          if (special) res <= special_res;
        end
        S_CALC: if (!mdu.abort) begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt - 1'b1;
        end
        S_FIX:  res <= fix_res;
        S_DONE: begin
          out_q  <= res;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mdu.MDU_out_S = out_q;
  assign mdu.done      = done_q;
  assign mdu.busy      = (state == S_CALC) || (state == S_FIX);
endmodule

// File: tb/tb_mdu_iterative.sv
// Purpose : directed self-checking bench for mdu_iterative.
// Latency : checks WIDTH+2 edge normal latency and 1 edge special-case latency.
// Backpressure: exercises ignored start while busy, abort, and start+abort in idle.
module tb_mdu_iterative;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mdu_if #(.WIDTH(32)) mdu ();

  mdu_iterative #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mdu  (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Issues one op, scrambles inputs after acceptance, and waits (bounded) for done.
  // lat = edges after the accepting edge until done is visible.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int bcyc);
    @(negedge clk);
    mdu.start = 1'b1; mdu.funct3 = f; mdu.MDU_in_X = x; mdu.MDU_in_Y = y;
    @(posedge clk);
    @(negedge clk);
    mdu.start = 1'b0;
    mdu.funct3 = 3'($urandom); mdu.MDU_in_X = $urandom; mdu.MDU_in_Y = $urandom;
    lat = 0; bcyc = 0;
    while (mdu.done !== 1'b1 && lat < 100) begin
      if (mdu.busy === 1'b1) bcyc++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    res = mdu.MDU_out_S;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mdu.start = 1'b0; mdu.abort = 1'b0; mdu.funct3 = '0; mdu.MDU_in_X = '0; mdu.MDU_in_Y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mdu.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", mdu.busy); end
    n_cmp++; if (mdu.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", mdu.done); end
    n_cmp++; if (mdu.MDU_out_S !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h want=0", mdu.MDU_out_S); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, bc;
    run_op(3'b000, 32'd2565, 32'd1560, r, lat, bc);
    n_cmp++; if (r !== 32'd4001400) begin n_err++; $display("FAIL mul_res got=%0d want=4001400", r); end
    n_cmp++; if (lat != 34) begin n_err++; $display("FAIL mul_latency got=%0d want=34", lat); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL mul_busy_cycles got=%0d want=33", bc); end
    n_cmp++; if (mdu.busy !== 1'b0) begin n_err++; $display("FAIL mul_busy_at_done got=%b want=0", mdu.busy); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (mdu.done !== 1'b0) begin n_err++; $display("FAIL mul_done_pulse got=%b want=0", mdu.done); end
    n_cmp++; if (mdu.MDU_out_S !== 32'd4001400) begin n_err++; $display("FAIL mul_hold got=%0d want=4001400", mdu.MDU_out_S); end
  endtask

  task automatic test_mul_high();
    vec_t tbl [4];
    logic [31:0] r; int lat, bc;
    tbl[0] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
    tbl[1] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    tbl[2] = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34};
    tbl[3] = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 34};
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].f, tbl[i].x, tbl[i].y, r, lat, bc);
      n_cmp++; if (r !== tbl[i].exp) begin n_err++; $display("FAIL mulhi_res[%0d] got=%h want=%h", i, r, tbl[i].exp); end
    end
  endtask

  task automatic test_div();
    vec_t tbl [10];
    logic [31:0] r; int lat, bc;
    tbl[0] = '{3'b100, 32'd2565, 32'd1560, 32'd1, 34};
    tbl[1] = '{3'b110, 32'd2565, 32'd1560, 32'd1005, 34};
    tbl[2] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34};
    tbl[3] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34};
    tbl[4] = '{3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34};
    tbl[5] = '{3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 34};
    tbl[6] = '{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
    tbl[7] = '{3'b111, 32'd5, 32'd0, 32'd5, 1};
    tbl[8] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[9] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].f, tbl[i].x, tbl[i].y, r, lat, bc);
      n_cmp++; if (r !== tbl[i].exp) begin n_err++; $display("FAIL div_res[%0d] got=%h want=%h", i, r, tbl[i].exp); end
      n_cmp++; if (lat != tbl[i].lat) begin n_err++; $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_start_ignored();
    int ndone; logic [31:0] got; logic busy5;
    @(negedge clk);
    mdu.start = 1'b1; mdu.funct3 = 3'b100; mdu.MDU_in_X = 32'd100; mdu.MDU_in_Y = 32'd7;
    @(posedge clk); @(negedge clk);
    mdu.start = 1'b0;
    ndone = 0; got = '0; busy5 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 5) begin
        busy5 = mdu.busy;
        mdu.start = 1'b1; mdu.funct3 = 3'b000; mdu.MDU_in_X = 32'd9; mdu.MDU_in_Y = 32'd9;
      end
      if (k == 6) mdu.start = 1'b0;
      if (mdu.done === 1'b1) begin ndone++; got = mdu.MDU_out_S; end
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (busy5 !== 1'b1) begin n_err++; $display("FAIL restart_busy got=%b want=1", busy5); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL restart_done_count got=%0d want=1", ndone); end
    n_cmp++; if (got !== 32'd14) begin n_err++; $display("FAIL restart_res got=%0d want=14", got); end
  endtask

  task automatic test_abort();
    logic [31:0] r; int lat, bc, ndone;
    run_op(3'b000, 32'd3, 32'd5, r, lat, bc);
    n_cmp++; if (r !== 32'd15) begin n_err++; $display("FAIL abort_pre_res got=%0d want=15", r); end
    @(negedge clk);
    mdu.start = 1'b1; mdu.funct3 = 3'b100; mdu.MDU_in_X = 32'd100; mdu.MDU_in_Y = 32'd7;
    @(posedge clk); @(negedge clk);
    mdu.start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    mdu.abort = 1'b1;
    @(posedge clk); @(negedge clk);
    mdu.abort = 1'b0;
    n_cmp++; if (mdu.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", mdu.busy); end
    ndone = 0;
    repeat (40) begin
      if (mdu.done === 1'b1) ndone++;
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL abort_done_count got=%0d want=0", ndone); end
    n_cmp++; if (mdu.MDU_out_S !== 32'd15) begin n_err++; $display("FAIL abort_out_kept got=%0d want=15", mdu.MDU_out_S); end
    // start and abort together in IDLE: start must not be taken
    mdu.start = 1'b1; mdu.abort = 1'b1; mdu.funct3 = 3'b000; mdu.MDU_in_X = 32'd4; mdu.MDU_in_Y = 32'd4;
    @(posedge clk); @(negedge clk);
    mdu.start = 1'b0; mdu.abort = 1'b0;
    n_cmp++; if (mdu.busy !== 1'b0) begin n_err++; $display("FAIL start_abort_busy got=%b want=0", mdu.busy); end
    ndone = 0;
    repeat (40) begin
      if (mdu.done === 1'b1) ndone++;
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL start_abort_done got=%0d want=0", ndone); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, bc;
    @(negedge clk);
    mdu.start = 1'b1; mdu.funct3 = 3'b000; mdu.MDU_in_X = 32'd2565; mdu.MDU_in_Y = 32'd1560;
    @(posedge clk); @(negedge clk);
    mdu.start = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (mdu.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b want=0", mdu.busy); end
    n_cmp++; if (mdu.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b want=0", mdu.done); end
    n_cmp++; if (mdu.MDU_out_S !== 32'h0) begin n_err++; $display("FAIL rstmid_out got=%h want=0", mdu.MDU_out_S); end
    run_op(3'b011, 32'h00010000, 32'h00030000, r, lat, bc);
    n_cmp++; if (r !== 32'h00000003) begin n_err++; $display("FAIL rstmid_after_res got=%h want=00000003", r); end
    n_cmp++; if (lat != 34) begin n_err++; $display("FAIL rstmid_after_latency got=%0d want=34", lat); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
